// File: rtl/gf180mcu_osu_sc_12t_clkdiv_n.sv
// Glitch-free programmable clock divider with a LOAD/ACK handshake for ratio changes.
// Optional run/stop gating input EN is enabled by defining GF180_CLKDIV_GATE_EN.
module gf180mcu_osu_sc_12t_clkdiv_n #(
   parameter int WIDTH       = 4,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             CLK,
   input  logic             R,
`ifdef GF180_CLKDIV_GATE_EN
   input  logic             EN,
`endif
   input  logic [WIDTH-1:0] DIV,
   input  logic             LOAD,
   output logic             ACK,
   output logic             Y,
   output logic             YN,
   output logic             TC
);

   localparam logic [WIDTH-1:0] DEF_RATIO = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

   typedef enum logic {S_IDLE, S_PENDING} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_nact;
   logic [WIDTH-1:0] r_npend;
   logic [WIDTH-1:0] w_div_clamp;
   logic [WIDTH-1:0] w_cnt_next;
   logic [WIDTH:0]   w_half;
   logic             w_wrap;
   logic             w_active;
   logic             w_bound;
   logic             w_capture;
   logic             w_adopt;
   logic             w_y_next;
   logic             r_y;
   logic             r_yn;
   logic             r_tc;
   logic             r_ack;

   assign w_div_clamp = (DIV < WIDTH'(2)) ? WIDTH'(2) : DIV;
   // High phase length; rounds up so odd ratios get the extra cycle high.
   assign w_half      = ({1'b0, r_nact} + (WIDTH+1)'(1)) >> 1;
   assign w_wrap      = (r_cnt == (r_nact - WIDTH'(1)));

`ifdef GF180_CLKDIV_GATE_EN
   logic r_run;

   // A stopped divider restarts on the very edge that first samples EN=1.
   assign w_active = r_run | EN;

   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         r_run <= 1'b1;
      end else if (w_active) begin
         r_run <= w_wrap ? EN : 1'b1;
      end else begin
         r_run <= 1'b0;
      end
   end
`else
   assign w_active = 1'b1;
`endif

   // While stopped, CNT is held at 0, which counts as a period boundary.
   assign w_bound = w_active ? w_wrap : 1'b1;

   // Handshake FSM: state register
   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Handshake FSM: next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (LOAD) w_state_next = S_PENDING;
         S_PENDING: if (!LOAD && w_bound) w_state_next = S_IDLE;
      endcase
   end

   // Handshake FSM: outputs; a LOAD on the boundary edge defers adoption.
   always_comb begin
      w_capture = LOAD;
      w_adopt   = (r_state == S_PENDING) && !LOAD && w_bound;
   end

   always_comb begin
      w_cnt_next = r_cnt + WIDTH'(1);
      if (!w_active || w_wrap) begin
         w_cnt_next = '0;
      end
   end

   assign w_y_next = w_active && ({1'b0, r_cnt} < w_half);

   always_ff @(posedge CLK or posedge R) begin
      if (R) begin
         r_cnt   <= '0;
         r_nact  <= DEF_RATIO;
         r_npend <= DEF_RATIO;
         r_y     <= 1'b0;
         r_yn    <= 1'b1;
         r_tc    <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         r_y   <= w_y_next;
         r_yn  <= ~w_y_next;
         r_tc  <= w_active && (r_cnt == '0);
         r_ack <= w_adopt;
         if (w_capture) begin
            r_npend <= w_div_clamp;
         end
         if (w_adopt) begin
            r_nact <= r_npend;
         end
      end
   end

   assign Y   = r_y;
   assign YN  = r_yn;
   assign TC  = r_tc;
   assign ACK = r_ack;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv_n.sv
// Directed, table-driven bench for the clock divider; gated-run sequence added
// when GF180_CLKDIV_GATE_EN is defined.
module tb_gf180mcu_osu_sc_12t_clkdiv_n;

   logic       CLK;
   logic       R;
   logic [3:0] DIV;
   logic       LOAD;
   logic       ACK;
   logic       Y;
   logic       YN;
   logic       TC;
`ifdef GF180_CLKDIV_GATE_EN
   logic       EN;
`endif

   int checks   = 0;
   int failures = 0;

   gf180mcu_osu_sc_12t_clkdiv_n #(.WIDTH(4), .DEFAULT_DIV(2)) dut (
      .CLK  (CLK),
      .R    (R),
`ifdef GF180_CLKDIV_GATE_EN
      .EN   (EN),
`endif
      .DIV  (DIV),
      .LOAD (LOAD),
      .ACK  (ACK),
      .Y    (Y),
      .YN   (YN),
      .TC   (TC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       load;
      logic [3:0] div;
      logic       ey;
      logic       etc;
      logic       eack;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic l, logic [3:0] d, logic y, logic t, logic a);
      vec_t v;
      v.load = l; v.div = d; v.ey = y; v.etc = t; v.eack = a;
      return v;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic ey, input logic etc, input logic eack);
      logic [3:0] act;
      logic [3:0] exp_v;
      act   = {Y, YN, TC, ACK};
      exp_v = {ey, ~ey, etc, eack};
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s t=%0t {Y,YN,TC,ACK} actual=%b required=%b", name, $time, act, exp_v);
      end else begin
         $display("ok   %s t=%0t {Y,YN,TC,ACK}=%b", name, $time, act);
      end
   endtask

   initial begin
      // ratio 2 free run
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,0,0,0));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,0,0,0));
      // LOAD 5 mid-period, adopted at the next wrap
      vq.push_back(mk(1,5,1,1,0)); vq.push_back(mk(0,0,0,0,1));
      for (int p = 0; p < 2; p++) begin
         vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,1,0,0));
         vq.push_back(mk(0,0,1,0,0)); vq.push_back(mk(0,0,0,0,0));
         vq.push_back(mk(0,0,0,0,0));
      end
      // LOAD 3 then LOAD 7 in the same period: one ACK, ratio 7
      vq.push_back(mk(1,3,1,1,0)); vq.push_back(mk(0,0,1,0,0));
      vq.push_back(mk(1,7,1,0,0)); vq.push_back(mk(0,0,0,0,0));
      vq.push_back(mk(0,0,0,0,1));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,1,0,0));
      vq.push_back(mk(0,0,1,0,0)); vq.push_back(mk(0,0,1,0,0));
      vq.push_back(mk(0,0,0,0,0)); vq.push_back(mk(0,0,0,0,0));
      vq.push_back(mk(0,0,0,0,0));
      // LOAD 0 clamps to 2
      vq.push_back(mk(1,0,1,1,0)); vq.push_back(mk(0,0,1,0,0));
      vq.push_back(mk(0,0,1,0,0)); vq.push_back(mk(0,0,1,0,0));
      vq.push_back(mk(0,0,0,0,0)); vq.push_back(mk(0,0,0,0,0));
      vq.push_back(mk(0,0,0,0,1));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,0,0,0));
      // LOAD 1 clamps to 2
      vq.push_back(mk(1,1,1,1,0)); vq.push_back(mk(0,0,0,0,1));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,0,0,0));
      // LOAD in IDLE on a wrap: capture only, ACK a period later (same ratio)
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(1,2,0,0,0));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,0,0,1));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,0,0,0));
      // LOAD while pending on a wrap: deferred, new value wins (ratio 4)
      vq.push_back(mk(1,3,1,1,0)); vq.push_back(mk(1,4,0,0,0));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,0,0,1));
      vq.push_back(mk(0,0,1,1,0)); vq.push_back(mk(0,0,1,0,0));
      vq.push_back(mk(0,0,0,0,0)); vq.push_back(mk(0,0,0,0,0));

      R = 1'b1; LOAD = 1'b0; DIV = 4'd0;
`ifdef GF180_CLKDIV_GATE_EN
      EN = 1'b1;
`endif
      #2;
      chk("reset_init", 1'b0, 1'b0, 1'b0);
      tick(); tick();
      chk("reset_held", 1'b0, 1'b0, 1'b0);
      R = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         LOAD = vq[i].load;
         DIV  = vq[i].div;
         tick();
         chk($sformatf("vec%0d", i), vq[i].ey, vq[i].etc, vq[i].eack);
      end
      LOAD = 1'b0;

      // Async reset during a pending ratio-9 request
      LOAD = 1'b1; DIV = 4'd9;
      tick();
      chk("load9", 1'b1, 1'b1, 1'b0);
      LOAD = 1'b0;
      #3;
      R = 1'b1;
      #1;
      chk("async_reset", 1'b0, 1'b0, 1'b0);
      tick();
      chk("async_reset_held", 1'b0, 1'b0, 1'b0);
      R = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("post_reset%0d", i), (i % 2) == 0, (i % 2) == 0, 1'b0);
      end

`ifdef GF180_CLKDIV_GATE_EN
      LOAD = 1'b1; DIV = 4'd4;
      tick(); chk("gate_load4", 1'b1, 1'b1, 1'b0);
      LOAD = 1'b0;
      tick(); chk("gate_ack4", 1'b0, 1'b0, 1'b1);
      tick(); chk("gate_c0", 1'b1, 1'b1, 1'b0);
      tick(); chk("gate_c1", 1'b1, 1'b0, 1'b0);
      EN = 1'b0;
      tick(); chk("gate_c2", 1'b0, 1'b0, 1'b0);
      tick(); chk("gate_c3", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk($sformatf("gate_stop%0d", i), 1'b0, 1'b0, 1'b0);
      end
      EN = 1'b1;
      tick(); chk("gate_run0", 1'b1, 1'b1, 1'b0);
      tick(); chk("gate_run1", 1'b1, 1'b0, 1'b0);
      tick(); chk("gate_run2", 1'b0, 1'b0, 1'b0);
      tick(); chk("gate_run3", 1'b0, 1'b0, 1'b0);
      tick(); chk("gate_run4", 1'b1, 1'b1, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
